// File: rtl/inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Requester side of the instruction-memory interface for the
//                multicycle RV32 core. Holds the PC, drives the ROM byte
//                address, captures the returned word into the instruction
//                register and hands it to the control FSM with a valid/ack
//                handshake. Supports PC redirects, in-flight abort, fault
//                detection (misaligned / out-of-range PC) and a fetch counter.
//
//  Parameters  : RESET_PC    - PC value loaded on reset
//                ROM_LATENCY - cycles from stable rom_addr to valid rom_inst
//                              (0 = combinational ROM, legal range 0..3)
//                ROM_ADDR_W  - byte-address width of the ROM port
//
//  Ports       : clock, reset       - clock, synchronous active-high reset
//                fetch_req          - request the next instruction (IDLE only)
//                inst_ack           - consume the held instruction (HOLD only)
//                pc_load, pc_in     - redirect the PC
//                rom_addr, rom_inst - ROM address out / instruction word in
//                ir, inst_valid     - instruction register and its valid flag
//                pc, pc_plus4       - current PC and PC + 4
//                busy               - fetch in flight
//                fetch_fault        - misaligned or out-of-range PC fetched
//                fetch_count        - instructions acknowledged since reset
//
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ROM_LATENCY = 0,
   parameter int          ROM_ADDR_W  = 17
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic                  inst_ack,
   input  logic                  pc_load,
   input  logic [31:0]           pc_in,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [31:0]           rom_inst,
   output logic [31:0]           ir,
   output logic                  inst_valid,
   output logic [31:0]           pc,
   output logic [31:0]           pc_plus4,
   output logic                  busy,
   output logic                  fetch_fault,
   output logic [31:0]           fetch_count
);

   localparam logic [31:0] c_NOP = 32'h0000_0013;

   // WAIT lasts exactly ROM_LATENCY cycles: the counter is loaded with
   // ROM_LATENCY-1 and the word is captured in the cycle it reads zero.
   localparam logic [1:0] c_WAIT_INIT = (ROM_LATENCY > 0) ? 2'(ROM_LATENCY - 1) : 2'd0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic        r_valid;
   logic        r_busy;
   logic        r_fault;
   logic [31:0] r_count;
   logic [1:0]  r_wait;

   logic [31:0] w_pc_plus4;
   logic        w_misaligned;
   logic        w_out_of_range;
   logic        w_fault;

   assign w_pc_plus4   = r_pc + 32'd4;
   assign w_misaligned = |r_pc[1:0];

   // Any PC bit above the ROM window makes the address unreachable.
   generate
      if (ROM_ADDR_W < 32) begin : g_range_check
         assign w_out_of_range = |r_pc[31:ROM_ADDR_W];
      end else begin : g_full_range
         assign w_out_of_range = 1'b0;
      end
   endgenerate

   assign w_fault = w_misaligned | w_out_of_range;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_ir    <= c_NOP;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_fault <= 1'b0;
         r_count <= 32'd0;
         r_wait  <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // A redirect wins over a fetch request in the same cycle.
               if (pc_load) begin
                  r_pc <= pc_in;
               end else if (fetch_req) begin
                  if (w_fault) begin
                     r_state <= S_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state <= S_REQ;
                     r_busy  <= 1'b1;
                  end
               end
            end

            S_REQ: begin
               if (pc_load) begin
                  // Abort: drop the in-flight fetch, ir keeps its old word.
                  r_pc    <= pc_in;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (ROM_LATENCY == 0) begin
                  r_ir    <= rom_inst;
                  r_state <= S_HOLD;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
               end else begin
                  r_wait  <= c_WAIT_INIT;
                  r_state <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (pc_load) begin
                  r_pc    <= pc_in;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_wait == 2'd0) begin
                  r_ir    <= rom_inst;
                  r_state <= S_HOLD;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
               end else begin
                  r_wait <= r_wait - 2'd1;
               end
            end

            S_HOLD: begin
               // pc_load without inst_ack is deliberately ignored here.
               if (inst_ack) begin
                  r_pc    <= pc_load ? pc_in : w_pc_plus4;
                  r_count <= r_count + 32'd1;
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end

            S_FAULT: begin
               if (pc_load) begin
                  r_pc    <= pc_in;
                  r_fault <= 1'b0;
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_fault <= 1'b0;
            end
         endcase
      end
   end

   assign rom_addr    = r_pc[ROM_ADDR_W-1:0];
   assign ir          = r_ir;
   assign inst_valid  = r_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign busy        = r_busy;
   assign fetch_fault = r_fault;
   assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Self-checking bench for inst_fetch_unit. Two instances share
//                one stimulus stream: dut0 with a combinational ROM and dut1
//                with a two-cycle registered ROM. Both ROMs return the
//                zero-extended byte address as the instruction word. A
//                behavioural model tracks each instance every cycle; a
//                vector table and hand-written sequences add fixed
//                expectations for the documented scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

   localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] c_NOP      = 32'h0000_0013;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_HOLD  = 2;
   localparam int M_FAULT = 3;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, fetch_req, inst_ack, pc_load;
   logic [31:0] pc_in;

   logic [16:0] rom_addr0, rom_addr1;
   logic [31:0] rom_inst0, rom_inst1;
   logic [31:0] ir0, ir1, pc0, pc1, pp0, pp1, cnt0, cnt1;
   logic        valid0, valid1, busy0, busy1, fault0, fault1;
   logic [31:0] rom_d1, rom_d2;

   assign rom_inst0 = {15'h0, rom_addr0};
   always @(posedge clock) begin
      rom_d1 <= {15'h0, rom_addr1};
      rom_d2 <= rom_d1;
   end
   assign rom_inst1 = rom_d2;

   inst_fetch_unit #(.RESET_PC(c_RESET_PC), .ROM_LATENCY(0), .ROM_ADDR_W(17)) dut0 (
      .clock(clock), .reset(reset), .fetch_req(fetch_req), .inst_ack(inst_ack),
      .pc_load(pc_load), .pc_in(pc_in), .rom_addr(rom_addr0), .rom_inst(rom_inst0),
      .ir(ir0), .inst_valid(valid0), .pc(pc0), .pc_plus4(pp0), .busy(busy0),
      .fetch_fault(fault0), .fetch_count(cnt0)
   );

   inst_fetch_unit #(.RESET_PC(c_RESET_PC), .ROM_LATENCY(2), .ROM_ADDR_W(17)) dut1 (
      .clock(clock), .reset(reset), .fetch_req(fetch_req), .inst_ack(inst_ack),
      .pc_load(pc_load), .pc_in(pc_in), .rom_addr(rom_addr1), .rom_inst(rom_inst1),
      .ir(ir1), .inst_valid(valid1), .pc(pc1), .pc_plus4(pp1), .busy(busy1),
      .fetch_fault(fault1), .fetch_count(cnt1)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- behavioural reference model ----------------
   int          m_lat  [2] = '{0, 2};
   int          m_mode [2];
   int          m_left [2];
   logic [31:0] m_pc   [2];
   logic [31:0] m_ir   [2];
   logic [31:0] m_cnt  [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at it.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_mode[k] = M_IDLE;
            m_pc[k]   = c_RESET_PC;
            m_ir[k]   = c_NOP;
            m_cnt[k]  = 0;
            m_left[k] = 0;
         end else begin
            case (m_mode[k])
               M_IDLE: begin
                  if (pc_load) m_pc[k] = pc_in;
                  else if (fetch_req) begin
                     if ((m_pc[k] % 4 != 0) || (m_pc[k] >= 32'h0002_0000)) m_mode[k] = M_FAULT;
                     else begin
                        m_mode[k] = M_FETCH;
                        m_left[k] = m_lat[k] + 1;  // request cycle plus ROM latency
                     end
                  end
               end
               M_FETCH: begin
                  if (pc_load) begin
                     m_pc[k]   = pc_in;
                     m_mode[k] = M_IDLE;
                  end else begin
                     m_left[k]--;
                     if (m_left[k] == 0) begin
                        m_ir[k]   = m_pc[k] & 32'h0001_FFFF;  // ROM content = address
                        m_mode[k] = M_HOLD;
                     end
                  end
               end
               M_HOLD: begin
                  if (inst_ack) begin
                     m_pc[k]   = pc_load ? pc_in : m_pc[k] + 32'd4;
                     m_cnt[k]  = m_cnt[k] + 32'd1;
                     m_mode[k] = M_IDLE;
                  end
               end
               default: begin
                  if (pc_load) begin
                     m_pc[k]   = pc_in;
                     m_mode[k] = M_IDLE;
                  end
               end
            endcase
         end
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("model%0d ir", k),       k ? ir1 : ir0, m_ir[k]);
         check($sformatf("model%0d pc", k),       k ? pc1 : pc0, m_pc[k]);
         check($sformatf("model%0d pc_plus4", k), k ? pp1 : pp0, m_pc[k] + 32'd4);
         check($sformatf("model%0d rom_addr", k), {15'h0, k ? rom_addr1 : rom_addr0}, m_pc[k] & 32'h0001_FFFF);
         check($sformatf("model%0d count", k),    k ? cnt1 : cnt0, m_cnt[k]);
         check($sformatf("model%0d valid", k),    32'(k ? valid1 : valid0), 32'(m_mode[k] == M_HOLD));
         check($sformatf("model%0d busy", k),     32'(k ? busy1 : busy0),   32'(m_mode[k] == M_FETCH));
         check($sformatf("model%0d fault", k),    32'(k ? fault1 : fault0), 32'(m_mode[k] == M_FAULT));
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic drive(input logic r, input logic fr, input logic ack, input logic ld, input logic [31:0] pin);
      reset = r; fetch_req = fr; inst_ack = ack; pc_load = ld; pc_in = pin;
   endtask

   // ---------------- vector table for the combinational-ROM instance ----------------
   typedef struct {
      logic        rst, fr, ack, ld;
      logic [31:0] pin;
      logic        v, b, f;
      logic [31:0] ir, pc, cnt;
   } vec_t;

   vec_t tv[$];

   initial begin
      int n_seen, prev_t;
      logic [31:0] sel;

      drive(1, 0, 0, 0, 0);

      //                rst fr ack ld pin            v  b  f  ir     pc            cnt
      tv.push_back('{1, 0, 0, 0, 32'h0,          0, 0, 0, c_NOP, 32'h0,        0}); // reset state
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 1, 0, c_NOP, 32'h0,        0}); // REQ
      tv.push_back('{0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0, 32'h0,        0}); // HOLD, ir=0
      tv.push_back('{0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h0, 32'h4,        1}); // ack
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 1, 0, 32'h0, 32'h4,        1});
      tv.push_back('{0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h4, 32'h4,        1});
      tv.push_back('{0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h4, 32'h8,        2});
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 1, 0, 32'h4, 32'h8,        2});
      tv.push_back('{0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h8, 32'h8,        2}); // HOLD pc=8
      tv.push_back('{0, 0, 1, 1, 32'h100,        0, 0, 0, 32'h8, 32'h100,      3}); // redirect on ack
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 1, 0, 32'h8, 32'h100,      3});
      tv.push_back('{0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h100, 32'h100,    3});
      tv.push_back('{0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h100, 32'h104,    4});
      tv.push_back('{0, 0, 0, 1, 32'h6,          0, 0, 0, 32'h100, 32'h6,      4}); // misaligned
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 0, 1, 32'h100, 32'h6,      4});
      tv.push_back('{0, 1, 1, 0, 32'h0,          0, 0, 1, 32'h100, 32'h6,      4}); // stuck in fault
      tv.push_back('{0, 0, 0, 1, 32'h8,          0, 0, 0, 32'h100, 32'h8,      4}); // clear fault
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 1, 0, 32'h100, 32'h8,      4});
      tv.push_back('{0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h8, 32'h8,        4});
      tv.push_back('{0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h8, 32'hC,        5});
      tv.push_back('{0, 0, 0, 1, 32'h2_0000,     0, 0, 0, 32'h8, 32'h2_0000,   5}); // out of range
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 0, 1, 32'h8, 32'h2_0000,   5});
      tv.push_back('{0, 0, 0, 1, 32'h10,         0, 0, 0, 32'h8, 32'h10,       5});
      tv.push_back('{0, 1, 0, 1, 32'h20,         0, 0, 0, 32'h8, 32'h20,       5}); // load beats fetch
      tv.push_back('{0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h8, 32'h20,       5}); // stray ack
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 1, 0, 32'h8, 32'h20,       5});
      tv.push_back('{0, 0, 0, 0, 32'h0,          1, 0, 0, 32'h20, 32'h20,      5});
      tv.push_back('{0, 0, 0, 1, 32'h300,        1, 0, 0, 32'h20, 32'h20,      5}); // load w/o ack ignored
      tv.push_back('{0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h20, 32'h24,      6});
      tv.push_back('{0, 0, 0, 1, 32'hFFFF_FFFC,  0, 0, 0, 32'h20, 32'hFFFF_FFFC, 6}); // pc+4 wraps
      tv.push_back('{0, 0, 0, 1, 32'h40,         0, 0, 0, 32'h20, 32'h40,      6});
      tv.push_back('{0, 1, 0, 0, 32'h0,          0, 1, 0, 32'h20, 32'h40,      6});
      tv.push_back('{0, 0, 0, 1, 32'h50,         0, 0, 0, 32'h20, 32'h50,      6}); // abort in REQ

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rst, tv[i].fr, tv[i].ack, tv[i].ld, tv[i].pin);
         step();
         check($sformatf("vec%0d valid", i), 32'(valid0), 32'(tv[i].v));
         check($sformatf("vec%0d busy", i),  32'(busy0),  32'(tv[i].b));
         check($sformatf("vec%0d fault", i), 32'(fault0), 32'(tv[i].f));
         check($sformatf("vec%0d ir", i),    ir0,  tv[i].ir);
         check($sformatf("vec%0d pc", i),    pc0,  tv[i].pc);
         check($sformatf("vec%0d pc_plus4", i), pp0, tv[i].pc + 32'd4);
         check($sformatf("vec%0d rom_addr", i), {15'h0, rom_addr0}, tv[i].pc & 32'h0001_FFFF);
         check($sformatf("vec%0d count", i), cnt0, tv[i].cnt);
      end

      // ---- sequential fetch on the latency-2 instance, req and ack held ----
      drive(1, 0, 0, 0, 0);
      step();
      drive(0, 1, 1, 0, 0);
      n_seen = 0;
      prev_t = 0;
      for (int t = 1; t <= 20; t++) begin
         step();
         if (valid1) begin
            check("seq ir", ir1, 32'(4 * n_seen));
            if (n_seen == 0) check("seq first latency", 32'(t), 32'd4);
            else             check("seq spacing", 32'(t - prev_t), 32'd5);
            prev_t = t;
            n_seen++;
         end
      end
      check("seq captures", 32'(n_seen), 32'd4);
      check("seq count", cnt1, 32'd4);

      // ---- abort during WAIT ----
      drive(1, 0, 0, 0, 0);
      step();
      drive(0, 1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0);
      step();
      check("abort busy in wait", 32'(busy1), 32'd1);
      drive(0, 0, 0, 1, 32'h40);
      step();
      check("abort valid", 32'(valid1), 32'd0);
      check("abort busy", 32'(busy1), 32'd0);
      check("abort pc", pc1, 32'h40);
      check("abort ir", ir1, c_NOP);
      check("abort count", cnt1, 32'd0);
      drive(0, 1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0);
      for (int t = 0; t < 3; t++) step();
      check("refetch valid", 32'(valid1), 32'd1);
      check("refetch ir", ir1, 32'h40);

      // ---- HOLD without ack for 10 cycles, stray req/load ignored ----
      drive(0, 1, 0, 1, 32'h80);
      for (int t = 0; t < 10; t++) begin
         step();
         check("hold valid", 32'(valid1), 32'd1);
         check("hold ir", ir1, 32'h40);
         check("hold pc", pc1, 32'h40);
      end

      // ---- reset in the middle of a fetch ----
      drive(0, 0, 1, 0, 0);
      step();
      check("ack pc", pc1, 32'h44);
      check("ack count", cnt1, 32'd1);
      drive(0, 1, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0);
      step();
      check("pre-reset busy", 32'(busy1), 32'd1);
      drive(1, 0, 0, 0, 0);
      step();
      check("mid reset busy", 32'(busy1), 32'd0);
      check("mid reset valid", 32'(valid1), 32'd0);
      check("mid reset fault", 32'(fault1), 32'd0);
      check("mid reset ir", ir1, c_NOP);
      check("mid reset pc", pc1, c_RESET_PC);
      check("mid reset count", cnt1, 32'd0);
      check("mid reset rom_addr", {15'h0, rom_addr1}, c_RESET_PC & 32'h0001_FFFF);

      // ---- randomized traffic against the model ----
      for (int t = 0; t < 4000; t++) begin
         sel = $urandom_range(0, 15);
         if (sel == 0)      pc_in = $urandom & 32'h0001_FFFF;
         else if (sel == 1) pc_in = $urandom;
         else if (sel == 2) pc_in = 32'hFFFF_FFFC;
         else               pc_in = ($urandom & 32'h0000_7FFF) << 2;
         reset     = ($urandom_range(0, 199) == 0);
         fetch_req = $urandom_range(0, 1) == 1;
         inst_ack  = $urandom_range(0, 1) == 1;
         pc_load   = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
